bcd_scan_decoder: RTL



---
 rtl/decoder_pkg.sv | 11 +
 rtl/onehot_decoder.sv | 17 +
 rtl/bcd_scan_decoder.sv | 71 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared sizing helpers and defaults for the scanned BCD decoder
package decoder_pkg;
  localparam int DEC_DEFAULT_N_OUT = 10;
  localparam int MAX_DIGITS = 64;
  function automatic int cw_of(input int n_out);
    return $clog2(n_out);
  endfunction
  function automatic logic [MAX_DIGITS-1:0] onehot(input int i);
    return MAX_DIGITS'(1) << i;
  endfunction
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: combinational code to one-hot decode with out-of-range flag
module onehot_decoder
  import decoder_pkg::*;
#(
  parameter int N_OUT = DEC_DEFAULT_N_OUT,
  localparam int CW = cw_of(N_OUT)
) (
  input  logic [CW-1:0]    code,
  output logic [0:N_OUT-1] s,
  output logic             inv
);
  always_comb begin
    s = '0;
    inv = int'(code) >= N_OUT;
    for (int i = 0; i < N_OUT; i++) s[i] = int'(code) == i;
  end
endmodule

// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder: time-multiplexed scan of N_DIGITS codes with frame-aligned updates
module bcd_scan_decoder
  import decoder_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int N_OUT = DEC_DEFAULT_N_OUT,
  parameter int DWELL = 1000,
  localparam int CW = cw_of(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [N_DIGITS*CW-1:0] digits,
  output logic [0:N_OUT-1]       s,
  output logic [N_DIGITS-1:0]    sel,
  output logic                   err,
  output logic                   frame
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int TW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [N_DIGITS*CW-1:0] shadow, active, active_n;
  logic pending, start, adv, wrap, boundary, inv;
  logic [TW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] code;
  logic [0:N_OUT-1] dec;
  // the start edge shows digit 0 at cnt 0 without counting, so the first digit also gets DWELL cycles
  always_comb begin
    adv = cnt == TW'(DWELL - 1);
    wrap = adv && idx == IW'(N_DIGITS - 1);
    boundary = start || wrap;
    cnt_n = (start || adv) ? '0 : cnt + 1'b1;
    idx_n = (start || wrap) ? '0 : adv ? idx + 1'b1 : idx;
    active_n = !boundary ? active : load ? digits : pending ? shadow : active;
    code = active_n[int'(idx_n)*CW +: CW];
  end
  onehot_decoder #(.N_OUT(N_OUT)) u_dec (.code(code), .s(dec), .inv(inv));
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pending <= 1'b0;
      start <= 1'b1;
      cnt <= '0;
      idx <= '0;
      s <= '0;
      sel <= '0;
      err <= 1'b0;
      frame <= 1'b0;
    end else begin
      if (load) shadow <= digits;
      pending <= (en && boundary) ? 1'b0 : (pending || load);
      if (en) begin
        cnt <= cnt_n;
        idx <= idx_n;
        active <= active_n;
        start <= 1'b0;
        frame <= boundary;
        sel <= N_DIGITS'(onehot(int'(idx_n)));
        s <= dec;
        err <= inv;
      end else begin
        frame <= 1'b0;
        sel <= '0;
        s <= '0;
        err <= 1'b0;
      end
    end
  end
endmodule
